// File: rtl/led_chain_pkg.sv
// led_chain_pkg: shared state/mode types and the reset divider for the LED chain sequencer.
package led_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } state_t;

    typedef enum logic [1:0] {
        MODE_UP,
        MODE_DOWN,
        MODE_PING,
        MODE_FILL
    } mode_t;

    localparam int LED_DEFAULT_DIV = 4;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: step-timing counter with enable and sync clear.
// o_tc marks the final count of each period while enabled.
module led_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_lastCnt;

    // A divider of zero behaves like one, so the chain still steps every cycle.
    assign w_lastCnt = (i_div == '0) ? '0 : i_div - DIV_W'(1);
    assign o_tc      = i_en && (r_cnt >= w_lastCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_chain_ctrl.sv
// led_chain_ctrl: run/freeze sequencer that steps a chase pattern along an LED chain.
// Define LED_CHAIN_FILL_EN to build the fill pattern for mode 3; otherwise mode 3 chases up.
module led_chain_ctrl
    import led_chain_pkg::*;
#(
    parameter int N_LEDS      = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = LED_DEFAULT_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                frz_req,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_mode,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic [N_LEDS-1:0]         led,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      step,
    output logic                      frozen
);

    localparam int                PW       = $clog2(N_LEDS);
    localparam logic [PW-1:0]     LAST_POS = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]     POS_ONE  = PW'(1);
    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

    state_t            r_state;
    mode_t             r_mode;
    logic [DIV_W-1:0]  r_div;
    logic [N_LEDS-1:0] r_led;
    logic [PW-1:0]     r_pos;
    logic              r_dirUp;
    logic              r_step;
    logic              r_frozen;
    logic              r_cfgReady;

    logic              w_freeze;
    logic              w_cfgXfer;
    logic              w_modeChange;
    logic              w_preEn;
    logic              w_preClr;
    logic              w_tc;
    logic [PW-1:0]     w_nextPos;
    logic              w_nextDir;
    logic [N_LEDS-1:0] w_nextLed;

    assign w_freeze     = |frz_req;
    assign w_cfgXfer    = cfg_valid && r_cfgReady && !stop;
    assign w_modeChange = (mode_t'(cfg_mode) != r_mode);
    assign w_preEn      = (r_state == RUN) && !w_freeze && !stop;
    assign w_preClr     = stop || (r_state == IDLE) || ((r_state == FROZEN) && w_cfgXfer);

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_preEn),
        .i_clr (w_preClr),
        .i_div (r_div),
        .o_tc  (w_tc)
    );

    // Next pattern position; ping-pong turns at the ends without repeating them.
    always_comb begin
        w_nextPos = (r_pos == LAST_POS) ? '0 : r_pos + POS_ONE;
        w_nextDir = r_dirUp;
        case (r_mode)
            MODE_DOWN: begin
                w_nextPos = (r_pos == '0) ? LAST_POS : r_pos - POS_ONE;
            end
            MODE_PING: begin
                if (r_dirUp) begin
                    if (r_pos == LAST_POS) begin
                        w_nextPos = r_pos - POS_ONE;
                        w_nextDir = 1'b0;
                    end else begin
                        w_nextPos = r_pos + POS_ONE;
                    end
                end else begin
                    if (r_pos == '0) begin
                        w_nextPos = POS_ONE;
                        w_nextDir = 1'b1;
                    end else begin
                        w_nextPos = r_pos - POS_ONE;
                    end
                end
            end
            default: ;
        endcase
        w_nextLed = LED_ONE << w_nextPos;
`ifdef LED_CHAIN_FILL_EN
        if (r_mode == MODE_FILL) begin
            w_nextLed = (r_pos == LAST_POS) ? LED_ONE : (r_led | (LED_ONE << w_nextPos));
        end
`endif
    end

    // stop outranks everything, including a pending config offer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mode     <= MODE_UP;
            r_div      <= DIV_W'(DEFAULT_DIV);
            r_led      <= '0;
            r_pos      <= '0;
            r_dirUp    <= 1'b1;
            r_step     <= 1'b0;
            r_frozen   <= 1'b0;
            r_cfgReady <= 1'b1;
        end else begin
            r_step <= 1'b0;
            if (stop) begin
                r_state    <= IDLE;
                r_led      <= '0;
                r_pos      <= '0;
                r_dirUp    <= 1'b1;
                r_frozen   <= 1'b0;
                r_cfgReady <= 1'b1;
            end else begin
                if (w_cfgXfer) begin
                    r_mode <= mode_t'(cfg_mode);
                    r_div  <= cfg_div;
                end
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_led   <= LED_ONE;
                            r_pos   <= '0;
                            r_dirUp <= 1'b1;
                            if (w_freeze) begin
                                r_state    <= FROZEN;
                                r_frozen   <= 1'b1;
                                r_cfgReady <= 1'b1;
                            end else begin
                                r_state    <= RUN;
                                r_frozen   <= 1'b0;
                                r_cfgReady <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (w_freeze) begin
                            r_state    <= FROZEN;
                            r_frozen   <= 1'b1;
                            r_cfgReady <= 1'b1;
                        end else if (w_tc) begin
                            r_step  <= 1'b1;
                            r_led   <= w_nextLed;
                            r_pos   <= w_nextPos;
                            r_dirUp <= w_nextDir;
                        end
                    end
                    FROZEN: begin
                        if (w_cfgXfer && w_modeChange) begin
                            r_led   <= LED_ONE;
                            r_pos   <= '0;
                            r_dirUp <= 1'b1;
                        end
                        if (!w_freeze) begin
                            r_state    <= RUN;
                            r_frozen   <= 1'b0;
                            r_cfgReady <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign led       = r_led;
    assign pos       = r_pos;
    assign step      = r_step;
    assign frozen    = r_frozen;
    assign cfg_ready = r_cfgReady;

endmodule
